// File: rtl/addf_serial_seq.sv
// -----------------------------------------------------------------------------
// addf_serial_seq
//
// Bit-serial add/subtract sequencer. One external full-adder cell is shared
// across a WIDTH-bit operation: one bit pair is streamed per clock, LSB first,
// and the carry is kept in a flip-flop between bits. Subtraction is done as
// A + ~B + 1, so the inverted B and the initial carry of 1 are loaded on
// accept.
//
// Handshake rules (both ports): a transfer happens on a rising CLK edge where
// VALID and READY are both high. IN_READY is high only in IDLE. OUT_VALID is
// high only in DONE. SUM/COUT/OVF stay stable there until OUT_READY is seen.
//
// Ports
//   CLK, RST            rising-edge clock; asynchronous active-high reset
//   IN_VALID/IN_READY   operation request handshake
//   OP_A, OP_B, SUB     operands and mode (1 = A - B); sampled only on accept
//   OUT_VALID/OUT_READY result handshake
//   SUM, COUT, OVF      result, final carry (no-borrow for subtract), and
//                       signed overflow; all forced to 0 unless OUT_VALID
//   FA_A, FA_B, FA_CI   drive the external full-adder cell (0 outside RUN)
//   FA_S, FA_CO         combinational outputs of that cell
//   DBG_STATE           current FSM state, for observation only
// -----------------------------------------------------------------------------
module addf_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] OP_A,
  input  logic [WIDTH-1:0] OP_B,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF,
  output logic             FA_A,
  output logic             FA_B,
  output logic             FA_CI,
  input  logic             FA_S,
  input  logic             FA_CO,
  output logic [1:0]       DBG_STATE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             c_msb;
  logic             accept;
  logic             last_bit;

  assign accept   = (state_q == IDLE) && IN_VALID;
  assign last_bit = (cnt == LAST_BIT);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and outputs.
  always_comb begin
    state_d   = state_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    FA_A      = 1'b0;
    FA_B      = 1'b0;
    FA_CI     = 1'b0;
    SUM       = '0;
    COUT      = 1'b0;
    OVF       = 1'b0;
    case (state_q)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_d = RUN;
      end
      RUN: begin
        FA_A  = a_sh[0];
        FA_B  = b_sh[0];
        FA_CI = carry;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        OUT_VALID = 1'b1;
        SUM       = sum_sh;
        COUT      = carry;
        // Carry into the MSB differs from carry out of it: signed overflow.
        OVF       = c_msb ^ carry;
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand shifters, result shifter, carry and bit counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      c_msb  <= 1'b0;
    end else if (accept) begin
      a_sh   <= OP_A;
      b_sh   <= OP_B ^ {WIDTH{SUB}};
      carry  <= SUB;
      cnt    <= '0;
      sum_sh <= '0;
    end else if (state_q == RUN) begin
      // Result bits enter at the top so the LSB lands at bit 0 after WIDTH shifts.
      sum_sh <= {FA_S, sum_sh[WIDTH-1:1]};
      carry  <= FA_CO;
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
      if (last_bit) c_msb <= carry;
    end
  end

  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_addf_serial_seq.sv
// -----------------------------------------------------------------------------
// tb_addf_serial_seq
//
// Bench for addf_serial_seq at WIDTH=8. The external full-adder cell is
// modelled combinationally here. Expected results come from plain integer
// arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_addf_serial_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         fa_a;
  logic         fa_b;
  logic         fa_ci;
  logic         fa_s;
  logic         fa_co;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Scoreboard of expected {cout, ovf, sum} per random operation.
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  addf_serial_seq #(.WIDTH(W)) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .OP_A      (op_a),
    .OP_B      (op_b),
    .SUB       (sub_i),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .SUM       (sum),
    .COUT      (cout),
    .OVF       (ovf),
    .FA_A      (fa_a),
    .FA_B      (fa_b),
    .FA_CI     (fa_ci),
    .FA_S      (fa_s),
    .FA_CO     (fa_co),
    .DBG_STATE (dbg_state)
  );

  // External full-adder cell.
  assign fa_s  = fa_a ^ fa_b ^ fa_ci;
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: integer add/subtract with unsigned carry and signed overflow.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    int ua, ub, sa, sb, r;
    logic [W-1:0] res;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    if (s) begin
      res = W'(ua - ub);
      c   = (ua >= ub);
      r   = sa - sb;
    end else begin
      res = W'(ua + ub);
      c   = (ua + ub) >= (1 << W);
      r   = sa + sb;
    end
    o = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    return {c, o, res};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] es, input logic ec,
                              input logic eo);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_zero_outs"}, 32'({sum, cout, ovf, fa_a, fa_b, fa_ci}), 32'd0);
  endtask

  // Driver: present an operation and return #1 after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    sub_i = s;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble inputs: only the accept edge may sample them.
    op_a = W'($urandom);
    op_b = W'($urandom);
    sub_i = 1'($urandom);
  endtask

  // Count edges after the accept edge until OUT_VALID appears.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!out_valid && lat < 100);
    chk("done_seen", 32'(out_valid), 32'd1);
  endtask

  // Hold the result for `hold` cycles, checking it each cycle, then retire it.
  task automatic retire(input int hold, input logic [W-1:0] es, input logic ec, input logic eo);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_result("hold", es, ec, eo);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("retired", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int t0, t1, acc_n;
    logic [W-1:0] ra, rb;
    logic rs;
    logic [W+1:0] e;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, sub: 1'b0, sum: 8'h96, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h10, b: 8'h20, sub: 1'b1, sum: 8'hF0, cout: 1'b0, ovf: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h01, sub: 1'b1, sum: 8'h7F, cout: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 8'h00, b: 8'h00, sub: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[5] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[6] = '{a: 8'h00, b: 8'h01, sub: 1'b1, sum: 8'hFF, cout: 1'b0, ovf: 1'b0};
    vecs[7] = '{a: 8'h80, b: 8'h80, sub: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    sub_i = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    #3;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed table, with latency and first-bit FA drive checks.
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
      chk("run_in_ready", 32'(in_ready), 32'd0);
      chk("run_fa_a0", 32'(fa_a), 32'(vecs[i].a[0]));
      chk("run_fa_b0", 32'(fa_b), 32'(vecs[i].b[0] ^ vecs[i].sub));
      chk("run_fa_ci0", 32'(fa_ci), 32'(vecs[i].sub));
      wait_done(lat);
      chk("latency", 32'(lat), 32'(W));
      check_result("vec", vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      retire(0, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
    end

    // Backpressure: DONE held 5 cycles while a new request waits.
    start_op(8'h5A, 8'h3C, 1'b0);
    wait_done(lat);
    in_valid = 1'b1;
    op_a = 8'h11;
    op_b = 8'h22;
    sub_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_result("bp", 8'h96, 1'b0, 1'b1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_retire_valid", 32'(out_valid), 32'd0);
    chk("bp_retire_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accepted_next", 32'(in_ready), 32'd0);
    wait_done(lat);
    chk("bp_latency", 32'(lat), 32'(W));
    check_result("bp_new", 8'h33, 1'b0, 1'b0);
    retire(0, 8'h33, 1'b0, 1'b0);

    // Reset in the middle of RUN (bit 3).
    start_op(8'hFF, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 2) @(posedge clk);
    #1;
    chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
    start_op(8'h01, 8'h01, 1'b0);
    wait_done(lat);
    check_result("post_rst", 8'h02, 1'b0, 1'b0);
    retire(0, 8'h02, 1'b0, 1'b0);

    // Reset while in DONE.
    start_op(8'h12, 8'h34, 1'b1);
    wait_done(lat);
    rst = 1'b1;
    #1;
    check_idle_outputs("done_rst");
    @(negedge clk);
    rst = 1'b0;

    // Throughput with OUT_READY tied high and IN_VALID held.
    out_ready = 1'b1;
    in_valid = 1'b1;
    op_a = 8'h01;
    op_b = 8'h02;
    t0 = 0;
    t1 = 0;
    acc_n = 0;
    for (int i = 0; i < 40 && acc_n < 2; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (acc_n == 0) t0 = cyc;
        else t1 = cyc;
        acc_n++;
      end
    end
    chk("tput_accepts", 32'(acc_n), 32'd2);
    chk("tput_period", 32'(t1 - t0), 32'(W + 2));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("tput_drained", 32'(in_ready), 32'd1);

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      exp_q.push_back(model(ra, rb, rs));
      start_op(ra, rb, rs);
      wait_done(lat);
      chk("rnd_latency", 32'(lat), 32'(W));
      e = exp_q.pop_front();
      check_result("rnd", e[W-1:0], e[W+1], e[W]);
      retire($urandom_range(0, 3), e[W-1:0], e[W+1], e[W]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/addf_serial_seq.md
# addf_serial_seq

Bit-serial add/subtract sequencer that time-shares one external `gf180mcu_osu_sc_9T_addf_1` full-adder cell across a WIDTH-bit operation. It streams one bit pair per clock, LSB first, and keeps the carry in a flip-flop between bits. Results are returned over a valid/ready handshake. It sits between an operand-producing requester and the full-adder cell, trading latency for area in small-footprint arithmetic paths.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  requester presents an operation.
- IN_READY  output  1  sequencer can accept; equals (state == IDLE).
- OP_A  input  WIDTH  minuend/augend, two's complement or unsigned.
- OP_B  input  WIDTH  subtrahend/addend.
- SUB  input  1  1 = A − B, 0 = A + B; sampled with the operands.
- OUT_VALID  output  1  result held and valid.
- OUT_READY  input  1  consumer accepts the result.
- SUM  output  WIDTH  result bits.
- COUT  output  1  final carry out; for subtract, 1 = no borrow.
- OVF  output  1  signed overflow: carry into the MSB XOR COUT.
- FA_A, FA_B, FA_CI  output  1 each  drive the external full-adder cell.
- FA_S, FA_CO  input  1 each  combinational outputs of that cell, sampled in the same cycle.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- **IDLE**
  - IN_READY=1.
  - On IN_VALID&IN_READY at a rising edge:
    - a_sh←OP_A.
    - b_sh←OP_B XOR {WIDTH{SUB}}.
    - carry←SUB.
    - cnt←0.
    - sum_sh←0.
    - Go to RUN.
- **RUN**
  - FA_A=a_sh[0], FA_B=b_sh[0], FA_CI=carry.
  - At each edge:
    - sum_sh←{FA_S, sum_sh[WIDTH-1:1]}.
    - carry←FA_CO.
    - a_sh and b_sh shift right by one, filling with 0.
    - cnt←cnt+1.
  - When cnt==WIDTH-1: capture c_msb←FA_CI, and go to DONE at that edge.
  - cnt width is clog2(WIDTH) bits. It never wraps during RUN.
- **DONE**
  - OUT_VALID=1.
  - SUM=sum_sh, COUT=carry, OVF=c_msb^carry. All three are held stable.
  - On OUT_READY go to IDLE.
  - IN_VALID is ignored, since IN_READY=0.
- FA_A, FA_B and FA_CI are 0 in IDLE and DONE.
- SUM, COUT and OVF are forced to 0 whenever OUT_VALID=0.
- Arithmetic is modulo 2^WIDTH. Unsigned callers use COUT; signed callers use OVF.
- Operands and SUB are only sampled on the accept edge. Changes at any other time have no effect.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE; all registers are 0.
  - IN_READY=1, OUT_VALID=0, SUM=0, COUT=0, OVF=0, FA_*=0.
- Reset release: the first accept is possible at the first rising edge after RST deasserts.
- Latency: accept at edge k gives RUN during cycles k..k+WIDTH−1, and OUT_VALID=1 after edge k+WIDTH.
- Throughput: with OUT_READY tied high, at most one operation per WIDTH+2 cycles.
- Backpressure: DONE is held indefinitely while OUT_READY=0. Outputs must not change.
- Simultaneous IN_VALID and OUT_READY in DONE: only the result is retired. The new request is accepted in the following IDLE cycle.
- Reset asserted mid-RUN or in DONE: the operation is discarded, no OUT_VALID pulse occurs, and the FSM returns to IDLE.
- The combinational path is FA_* out → cell → FA_S/FA_CO in → registers, all within one clock period.

## Test plan
- Add 0x5A+0x3C (SUB=0, WIDTH=8) -> SUM=0x96, COUT=0, OVF=1. OUT_VALID rises exactly 8 cycles after the accept edge.
- Add 0xFF+0x01 -> SUM=0x00, COUT=1, OVF=0.
- Subtract 0x10−0x20 -> SUM=0xF0, COUT=0 (borrow), OVF=0.
- Subtract 0x80−0x01 -> SUM=0x7F, COUT=1, OVF=1.
- Backpressure:
  - Stimulus: hold OUT_READY=0 for 5 cycles in DONE while IN_VALID=1 with new operands.
  - Required response: SUM, COUT and OVF are unchanged and IN_READY stays 0. The next operation is accepted one cycle after OUT_READY=1.
- Reset mid-RUN:
  - Stimulus: assert RST at bit 3 of an 8-bit add.
  - Required response: all outputs are immediately 0 and IN_READY=1. A fresh add 0x01+0x01 after release yields SUM=0x02 with no residual carry.
